// File: rtl/matrix_stream_loader_pkg.sv
// ---------------------------------------------------------------------------
// matrix_loader_pkg
// Shared definitions for the matrix stream loader:
//   - state_t     : loader FSM states
//   - CTRL_*      : beat kinds carried on in_ctrl
//   - ERR_*       : values reported on err_code
//   - DEF_*       : default element width and maximum matrix dimension
// ---------------------------------------------------------------------------
package matrix_loader_pkg;

  localparam int DEF_ELEM_W  = 8;
  localparam int DEF_MAX_DIM = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_LOAD_A = 3'd2,
    ST_LOAD_B = 3'd3,
    ST_HOLD   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  localparam logic [1:0] CTRL_DATA = 2'd0;
  localparam logic [1:0] CTRL_HDR  = 2'd1;
  localparam logic [1:0] CTRL_CLR  = 2'd2;
  localparam logic [1:0] CTRL_RSVD = 2'd3;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_DIM   = 2'd1;
  localparam logic [1:0] ERR_SHAPE = 2'd2;
  localparam logic [1:0] ERR_SEQ   = 2'd3;

endpackage

// File: rtl/matrix_stream_loader.sv
// ---------------------------------------------------------------------------
// matrix_stream_loader
// Accepts a ready/valid beat stream: a 4-beat dimension header (R1, C1, R2,
// C2) followed by matrix A (R1 x C1) and matrix B (R2 x C2), both row-major.
// Elements are packed into flat MAX_DIM x MAX_DIM buffers (slot
// row*MAX_DIM+col), unused slots zero, and handed to the multiplier with a
// mat_valid/mat_ready handshake. Malformed streams raise a sticky error that
// only a CLR beat removes.
//
// Ports:
//   CLK, RST_N         clock, asynchronous active-low reset
//   in_data            header value or matrix element
//   in_ctrl            beat kind (DATA / HDR / CLR / reserved)
//   in_valid, in_ready input handshake; in_ready depends on state only
//   mat_a, mat_b       packed matrices, slot k = [k*ELEM_W +: ELEM_W]
//   r1, c1, r2, c2     latched dimensions
//   mat_valid          matrices complete and stable
//   mat_ready          multiplier takes the matrices
//   err, err_code      sticky error flag and cause (NONE/DIM/SHAPE/SEQ)
// ---------------------------------------------------------------------------
module matrix_stream_loader
  import matrix_loader_pkg::*;
#(
  parameter int ELEM_W  = DEF_ELEM_W,
  parameter int MAX_DIM = DEF_MAX_DIM,
  parameter int DIM_W   = $clog2(MAX_DIM + 1)
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic [ELEM_W-1:0]                 in_data,
  input  logic [1:0]                        in_ctrl,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] mat_a,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] mat_b,
  output logic [DIM_W-1:0]                  r1,
  output logic [DIM_W-1:0]                  c1,
  output logic [DIM_W-1:0]                  r2,
  output logic [DIM_W-1:0]                  c2,
  output logic                              mat_valid,
  input  logic                              mat_ready,
  output logic                              err,
  output logic [1:0]                        err_code
);

  localparam int NSLOT = MAX_DIM * MAX_DIM;
  // MAX_DIM >= 2 guarantees at least 4 slots, so IDX_W >= 2.
  localparam int IDX_W = $clog2(NSLOT);
  localparam logic [DIM_W-1:0] MAX_D = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] ONE_D = DIM_W'(1);

  state_t           state;
  logic [1:0]       hdr_cnt;    // header beats already taken (1..3 while in HDR)
  logic [DIM_W-1:0] row;
  logic [DIM_W-1:0] col;
  logic             hdr_ovf;    // R1 beat had bits above DIM_W; reported at header end

  logic             accept;
  logic [DIM_W-1:0] beat_dim;
  logic             beat_hi;
  logic             hdr_dim_err;
  logic             hdr_shape_err;
  logic [IDX_W-1:0] wr_idx;
  logic             a_col_end;
  logic             a_last;
  logic             b_col_end;
  logic             b_last;
  logic             raise;
  logic [1:0]       raise_code;

  function automatic logic dim_bad(input logic [DIM_W-1:0] d);
    return (d == '0) || (d > MAX_D);
  endfunction

  // MAX_DIM is a constant, so the multiply reduces to wiring when it is a
  // power of two and to a small constant adder tree otherwise.
  function automatic logic [IDX_W-1:0] slot_idx(input logic [DIM_W-1:0] r,
                                                input logic [DIM_W-1:0] c);
    return IDX_W'(r) * IDX_W'(MAX_DIM) + IDX_W'(c);
  endfunction

  assign accept   = in_valid & in_ready;
  assign beat_dim = in_data[DIM_W-1:0];
  assign beat_hi  = (in_data >> DIM_W) != '0;

  // Evaluated on the 4th header beat: R1/C1/R2 are latched, C2 is on the bus.
  assign hdr_dim_err = hdr_ovf | beat_hi | dim_bad(r1) | dim_bad(c1) |
                       dim_bad(r2) | dim_bad(beat_dim);
  assign hdr_shape_err = (c1 != r2);

  assign wr_idx    = slot_idx(row, col);
  assign a_col_end = (col == c1 - ONE_D);
  assign a_last    = a_col_end && (row == r1 - ONE_D);
  assign b_col_end = (col == c2 - ONE_D);
  assign b_last    = b_col_end && (row == r2 - ONE_D);

  // Error decode for the beat being accepted this cycle. CLR always wins and
  // the ERR state swallows everything else, so neither can raise here.
  always_comb begin
    raise      = 1'b0;
    raise_code = ERR_NONE;
    if (accept && (in_ctrl != CTRL_CLR) && (state != ST_ERR) && (state != ST_HOLD)) begin
      if (in_ctrl == CTRL_RSVD) begin
        raise      = 1'b1;
        raise_code = ERR_SEQ;
      end else begin
        case (state)
          ST_IDLE: begin
            if (in_ctrl == CTRL_DATA) begin
              raise      = 1'b1;
              raise_code = ERR_SEQ;
            end
          end
          ST_HDR: begin
            if (in_ctrl == CTRL_DATA) begin
              raise      = 1'b1;
              raise_code = ERR_SEQ;
            end else if (hdr_cnt == 2'd3) begin
              if (hdr_dim_err) begin
                raise      = 1'b1;
                raise_code = ERR_DIM;
              end else if (hdr_shape_err) begin
                raise      = 1'b1;
                raise_code = ERR_SHAPE;
              end
            end else if (beat_hi) begin
              raise      = 1'b1;
              raise_code = ERR_DIM;
            end
          end
          ST_LOAD_A, ST_LOAD_B: begin
            if (in_ctrl == CTRL_HDR) begin
              raise      = 1'b1;
              raise_code = ERR_SEQ;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      hdr_cnt   <= '0;
      hdr_ovf   <= 1'b0;
      row       <= '0;
      col       <= '0;
      mat_a     <= '0;
      mat_b     <= '0;
      r1        <= '0;
      c1        <= '0;
      r2        <= '0;
      c2        <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      mat_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (state == ST_HOLD) begin
      // Nothing is accepted while holding; only the multiplier releases us.
      if (mat_ready) begin
        state     <= ST_IDLE;
        mat_valid <= 1'b0;
        in_ready  <= 1'b1;
      end
    end else if (accept) begin
      // Dimension fields follow the header beats even when the header is
      // later rejected, so the offending values stay visible on r1..c2.
      if (in_ctrl == CTRL_HDR) begin
        if (state == ST_IDLE) begin
          r1      <= beat_dim;
          hdr_ovf <= beat_hi;
        end else if (state == ST_HDR) begin
          case (hdr_cnt)
            2'd1:    c1 <= beat_dim;
            2'd2:    r2 <= beat_dim;
            default: c2 <= beat_dim;
          endcase
        end
      end

      if (in_ctrl == CTRL_CLR) begin
        state    <= ST_IDLE;
        err      <= 1'b0;
        err_code <= ERR_NONE;
        hdr_cnt  <= '0;
        hdr_ovf  <= 1'b0;
        row      <= '0;
        col      <= '0;
      end else if (raise) begin
        state    <= ST_ERR;
        err      <= 1'b1;
        err_code <= raise_code;
      end else begin
        // Without a raise, IDLE/HDR can only see HDR beats and LOAD_* only DATA.
        case (state)
          ST_IDLE: begin
            hdr_cnt <= 2'd1;
            state   <= ST_HDR;
          end
          ST_HDR: begin
            hdr_cnt <= hdr_cnt + 2'd1;
            if (hdr_cnt == 2'd3) begin
              mat_a <= '0;
              mat_b <= '0;
              row   <= '0;
              col   <= '0;
              state <= ST_LOAD_A;
            end
          end
          ST_LOAD_A: begin
            mat_a[int'(wr_idx)*ELEM_W +: ELEM_W] <= in_data;
            if (a_last) begin
              row   <= '0;
              col   <= '0;
              state <= ST_LOAD_B;
            end else if (a_col_end) begin
              col <= '0;
              row <= row + ONE_D;
            end else begin
              col <= col + ONE_D;
            end
          end
          ST_LOAD_B: begin
            mat_b[int'(wr_idx)*ELEM_W +: ELEM_W] <= in_data;
            if (b_last) begin
              row       <= '0;
              col       <= '0;
              state     <= ST_HOLD;
              mat_valid <= 1'b1;
              in_ready  <= 1'b0;
            end else if (b_col_end) begin
              col <= '0;
              row <= row + ONE_D;
            end else begin
              col <= col + ONE_D;
            end
          end
          default: ;  // ERR: beat dropped
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_matrix_stream_loader
// Directed sequences, a table of single-beat vectors for error/CLR/HOLD
// behaviour, and a randomized stream checked against a transaction-level
// model of the loader.
// ---------------------------------------------------------------------------
module tb_matrix_stream_loader;
  import matrix_loader_pkg::*;

  localparam int EW = 8;
  localparam int MD = 4;
  localparam int DW = $clog2(MD + 1);
  localparam int NS = MD * MD;
  localparam int MW = NS * EW;

  localparam int P_IDLE = 0, P_HDR = 1, P_A = 2, P_B = 3, P_HOLD = 4, P_ERR = 5;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [EW-1:0] in_data = '0;
  logic [1:0]    in_ctrl = CTRL_DATA;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] mat_a, mat_b;
  logic [DW-1:0] r1, c1, r2, c2;
  logic          mat_valid;
  logic          mat_ready = 1'b0;
  logic          err;
  logic [1:0]    err_code;

  matrix_stream_loader #(.ELEM_W(EW), .MAX_DIM(MD)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_data(in_data), .in_ctrl(in_ctrl),
    .in_valid(in_valid), .in_ready(in_ready), .mat_a(mat_a), .mat_b(mat_b),
    .r1(r1), .c1(c1), .r2(r2), .c2(c2), .mat_valid(mat_valid),
    .mat_ready(mat_ready), .err(err), .err_code(err_code)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] put(input logic [MW-1:0] m, input int k, input int v);
    logic [MW-1:0] r;
    r = m;
    r[k*EW +: EW] = 8'(v);
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send(input logic [1:0] c, input logic [7:0] d, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_ctrl  = c;
    in_data  = d;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    chk("send_accept_wait", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mat_a"}, mat_a, '0);
    chk({tag, ".mat_b"}, mat_b, '0);
    chk({tag, ".dims"}, {r1, c1, r2, c2}, '0);
    chk({tag, ".flags"}, {in_ready, mat_valid, err, err_code}, 5'b10000);
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic       v;
    logic [1:0] c;
    logic [7:0] d;
    logic       mr;
    logic       rdy;
    logic       mv;
    logic       e;
    logic [1:0] code;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [1:0] c, input int d, input logic mr,
                              input logic rdy, input logic mv, input logic e, input logic [1:0] code);
    vec_t x;
    x.v = v; x.c = c; x.d = 8'(d); x.mr = mr;
    x.rdy = rdy; x.mv = mv; x.e = e; x.code = code;
    return x;
  endfunction

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [1:0] c;
    logic [7:0] d;
  } beat_t;

  beat_t q[$];
  int    m_phase, m_nh, m_n;
  int    md[4];
  int    ma[NS];
  int    mb[NS];
  logic  m_err;
  logic [1:0] m_code;

  task automatic model_reset();
    m_phase = P_IDLE; m_nh = 0; m_n = 0; m_err = 1'b0; m_code = ERR_NONE;
    for (int k = 0; k < 4; k++) md[k] = 0;
    for (int k = 0; k < NS; k++) begin ma[k] = 0; mb[k] = 0; end
  endtask

  task automatic m_raise(input logic [1:0] code);
    m_phase = P_ERR;
    m_err   = 1'b1;
    m_code  = code;
  endtask

  task automatic model_beat(input logic [1:0] c, input logic [7:0] d);
    bit bad;
    if (c == CTRL_CLR) begin
      m_phase = P_IDLE; m_err = 1'b0; m_code = ERR_NONE; m_nh = 0; m_n = 0;
    end else if (m_phase == P_ERR) begin
      // dropped
    end else if (c == CTRL_RSVD) begin
      m_raise(ERR_SEQ);
    end else begin
      case (m_phase)
        P_IDLE: begin
          if (c == CTRL_HDR) begin md[0] = int'(d); m_nh = 1; m_phase = P_HDR; end
          else m_raise(ERR_SEQ);
        end
        P_HDR: begin
          if (c == CTRL_DATA) m_raise(ERR_SEQ);
          else begin
            md[m_nh] = int'(d);
            m_nh++;
            if (m_nh == 4) begin
              bad = 0;
              for (int k = 0; k < 4; k++) if (md[k] < 1 || md[k] > MD) bad = 1;
              if (bad) m_raise(ERR_DIM);
              else if (md[1] != md[2]) m_raise(ERR_SHAPE);
              else begin
                for (int k = 0; k < NS; k++) begin ma[k] = 0; mb[k] = 0; end
                m_n = 0;
                m_phase = P_A;
              end
            end
          end
        end
        P_A: begin
          if (c == CTRL_HDR) m_raise(ERR_SEQ);
          else begin
            ma[(m_n / md[1]) * MD + (m_n % md[1])] = int'(d);
            m_n++;
            if (m_n == md[0] * md[1]) begin m_n = 0; m_phase = P_B; end
          end
        end
        P_B: begin
          if (c == CTRL_HDR) m_raise(ERR_SEQ);
          else begin
            mb[(m_n / md[3]) * MD + (m_n % md[3])] = int'(d);
            m_n++;
            if (m_n == md[2] * md[3]) begin m_n = 0; m_phase = P_HOLD; end
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [MW-1:0] pack(input int a[NS]);
    logic [MW-1:0] m;
    m = '0;
    for (int k = 0; k < NS; k++) m[k*EW +: EW] = 8'(a[k]);
    return m;
  endfunction

  task automatic model_compare();
    chk("rnd.in_ready", in_ready, m_phase != P_HOLD);
    chk("rnd.mat_valid", mat_valid, m_phase == P_HOLD);
    chk("rnd.err", err, m_err);
    chk("rnd.err_code", err_code, m_code);
    chk("rnd.mat_a", mat_a, pack(ma));
    chk("rnd.mat_b", mat_b, pack(mb));
    chk("rnd.dims", {r1, c1, r2, c2}, {DW'(md[0]), DW'(md[1]), DW'(md[2]), DW'(md[3])});
  endtask

  function automatic beat_t mkb(input logic [1:0] c, input int d);
    beat_t b;
    b.c = c;
    b.d = 8'(d);
    // occasional corruption of the beat kind
    if ($urandom_range(0, 99) < 4) b.c = 2'($urandom_range(0, 3));
    return b;
  endfunction

  task automatic gen_txn();
    int d[4];
    int ne;
    beat_t b;
    b.c = CTRL_CLR; b.d = '0;
    q.push_back(b);
    if ($urandom_range(0, 99) < 85) begin
      d[0] = $urandom_range(1, MD); d[1] = $urandom_range(1, MD);
      d[2] = d[1];                  d[3] = $urandom_range(1, MD);
    end else begin
      for (int k = 0; k < 4; k++) d[k] = $urandom_range(0, 6);
    end
    for (int k = 0; k < 4; k++) q.push_back(mkb(CTRL_HDR, d[k]));
    ne = 3;
    if (d[0] >= 1 && d[0] <= MD && d[1] >= 1 && d[1] <= MD && d[3] >= 1 && d[3] <= MD && d[1] == d[2])
      ne = d[0] * d[1] + d[2] * d[3];
    for (int i = 0; i < ne; i++) q.push_back(mkb(CTRL_DATA, $urandom_range(0, 255)));
  endtask

  bit acc;
  int cyc;

  initial begin
    logic [MW-1:0] ea, eb;

    // ---------------- reset state ----------------
    #12;
    chk_all_zero("reset");
    @(negedge CLK);
    RST_N = 1'b1;
    tick();

    // ---------------- 2x2 x 2x2, hold then release ----------------
    for (int i = 0; i < 4; i++) send(CTRL_HDR, 2, 0);
    for (int i = 1; i <= 4; i++) send(CTRL_DATA, i, 0);
    for (int i = 5; i <= 7; i++) send(CTRL_DATA, i, 0);
    chk("t1.mv_before_last", mat_valid, 1'b0);
    send(CTRL_DATA, 8, 0);
    ea = put(put(put(put('0, 0, 1), 1, 2), 4, 3), 5, 4);
    eb = put(put(put(put('0, 0, 5), 1, 6), 4, 7), 5, 8);
    chk("t1.mv_after_last", mat_valid, 1'b1);
    chk("t1.dims", {r1, c1, r2, c2}, {3'd2, 3'd2, 3'd2, 3'd2});
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1.hold_mv", mat_valid, 1'b1);
      chk("t1.hold_rdy", in_ready, 1'b0);
      chk("t1.hold_a", mat_a, ea);
      chk("t1.hold_b", mat_b, eb);
    end
    mat_ready = 1'b1;
    tick();
    mat_ready = 1'b0;
    chk("t1.release", {mat_valid, in_ready, err}, 3'b010);

    // ---------------- 3x2 x 2x4 with gaps ----------------
    send(CTRL_HDR, 3, $urandom_range(0, 3));
    send(CTRL_HDR, 2, $urandom_range(0, 3));
    send(CTRL_HDR, 2, $urandom_range(0, 3));
    send(CTRL_HDR, 4, $urandom_range(0, 3));
    for (int i = 1; i <= 6; i++) send(CTRL_DATA, i, $urandom_range(0, 3));
    for (int i = 11; i <= 17; i++) send(CTRL_DATA, i, $urandom_range(0, 3));
    chk("t2.mv_before_last", mat_valid, 1'b0);
    send(CTRL_DATA, 18, $urandom_range(0, 3));
    chk("t2.mv_after_last", mat_valid, 1'b1);
    ea = '0;
    ea = put(put(put(ea, 0, 1), 1, 2), 4, 3);
    ea = put(put(put(ea, 5, 4), 8, 5), 9, 6);
    eb = '0;
    for (int k = 0; k < 8; k++) eb = put(eb, k, 11 + k);
    chk("t2.a_slot9", mat_a[9*EW +: EW], 8'd6);
    chk("t2.mat_a", mat_a, ea);
    chk("t2.mat_b", mat_b, eb);
    chk("t2.dims", {r1, c1, r2, c2}, {3'd3, 3'd2, 3'd2, 3'd4});
    mat_ready = 1'b1;
    tick();
    mat_ready = 1'b0;
    chk("t2.release", {mat_valid, in_ready}, 2'b01);

    // ---------------- error / CLR / 1x1 / HOLD vectors ----------------
    tbl.push_back(mk(1, CTRL_HDR, 2, 0, 1, 0, 0, ERR_NONE));
    tbl.push_back(mk(1, CTRL_HDR, 3, 0, 1, 0, 0, ERR_NONE));
    tbl.push_back(mk(1, CTRL_HDR, 2, 0, 1, 0, 0, ERR_NONE));
    tbl.push_back(mk(1, CTRL_HDR, 2, 0, 1, 0, 1, ERR_SHAPE));
    tbl.push_back(mk(1, CTRL_DATA, 9, 0, 1, 0, 1, ERR_SHAPE));
    tbl.push_back(mk(1, CTRL_RSVD, 0, 0, 1, 0, 1, ERR_SHAPE));
    tbl.push_back(mk(0, CTRL_DATA, 0, 0, 1, 0, 1, ERR_SHAPE));
    tbl.push_back(mk(1, CTRL_CLR, 0, 0, 1, 0, 0, ERR_NONE));
    tbl.push_back(mk(1, CTRL_DATA, 1, 0, 1, 0, 1, ERR_SEQ));
    tbl.push_back(mk(1, CTRL_CLR, 0, 0, 1, 0, 0, ERR_NONE));
    tbl.push_back(mk(1, CTRL_HDR, 5, 0, 1, 0, 0, ERR_NONE));
    tbl.push_back(mk(1, CTRL_HDR, 1, 0, 1, 0, 0, ERR_NONE));
    tbl.push_back(mk(1, CTRL_HDR, 1, 0, 1, 0, 0, ERR_NONE));
    tbl.push_back(mk(1, CTRL_HDR, 1, 0, 1, 0, 1, ERR_DIM));
    tbl.push_back(mk(1, CTRL_CLR, 0, 0, 1, 0, 0, ERR_NONE));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, CTRL_HDR, 1, 0, 1, 0, 0, ERR_NONE));
    tbl.push_back(mk(1, CTRL_RSVD, 0, 0, 1, 0, 1, ERR_SEQ));
    tbl.push_back(mk(1, CTRL_CLR, 0, 0, 1, 0, 0, ERR_NONE));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, CTRL_HDR, 1, 0, 1, 0, 0, ERR_NONE));
    tbl.push_back(mk(1, CTRL_DATA, 7, 0, 1, 0, 0, ERR_NONE));
    tbl.push_back(mk(1, CTRL_DATA, 9, 0, 0, 1, 0, ERR_NONE));
    tbl.push_back(mk(1, CTRL_CLR, 0, 0, 0, 1, 0, ERR_NONE));
    tbl.push_back(mk(1, CTRL_CLR, 0, 0, 0, 1, 0, ERR_NONE));
    tbl.push_back(mk(0, CTRL_DATA, 0, 1, 1, 0, 0, ERR_NONE));
    tbl.push_back(mk(0, CTRL_DATA, 0, 1, 1, 0, 0, ERR_NONE));
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid  = tbl[i].v;
      in_ctrl   = tbl[i].c;
      in_data   = tbl[i].d;
      mat_ready = tbl[i].mr;
      tick();
      chk($sformatf("tbl%0d.in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d.mat_valid", i), mat_valid, tbl[i].mv);
      chk($sformatf("tbl%0d.err", i), err, tbl[i].e);
      chk($sformatf("tbl%0d.err_code", i), err_code, tbl[i].code);
    end
    in_valid  = 1'b0;
    mat_ready = 1'b0;
    chk("t1x1.mat_a", mat_a, put('0, 0, 7));
    chk("t1x1.mat_b", mat_b, put('0, 0, 9));
    chk("t1x1.dims", {r1, c1, r2, c2}, {3'd1, 3'd1, 3'd1, 3'd1});

    // ---------------- reset in the middle of LOAD_A ----------------
    for (int i = 0; i < 4; i++) send(CTRL_HDR, 2, 0);
    for (int i = 1; i <= 3; i++) send(CTRL_DATA, 8'h40 + i, 0);
    chk("rst.partial_a", mat_a[4*EW +: EW], 8'h43);
    #2;
    RST_N = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send(CTRL_HDR, 2, 0);
    for (int i = 1; i <= 8; i++) send(CTRL_DATA, 8'h20 + i, 0);
    ea = put(put(put(put('0, 0, 8'h21), 1, 8'h22), 4, 8'h23), 5, 8'h24);
    eb = put(put(put(put('0, 0, 8'h25), 1, 8'h26), 4, 8'h27), 5, 8'h28);
    chk("rst.after_mv", mat_valid, 1'b1);
    chk("rst.after_a", mat_a, ea);
    chk("rst.after_b", mat_b, eb);
    mat_ready = 1'b1;
    tick();
    mat_ready = 1'b0;

    // ---------------- randomized stream vs model ----------------
    RST_N = 1'b0;
    #1;
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    for (int tr = 0; tr < 40; tr++) gen_txn();
    cyc = 0;
    while ((q.size() > 0 || m_phase == P_HOLD) && cyc < 20000) begin
      in_valid = (q.size() > 0) && ($urandom_range(0, 9) < 7);
      if (q.size() > 0) begin
        in_ctrl = q[0].c;
        in_data = q[0].d;
      end
      mat_ready = ($urandom_range(0, 9) < 4);
      acc = in_valid && (m_phase != P_HOLD);
      @(posedge CLK);
      if (m_phase == P_HOLD) begin
        if (mat_ready) m_phase = P_IDLE;
      end else if (acc) begin
        model_beat(q[0].c, q[0].d);
        void'(q.pop_front());
      end
      #1;
      model_compare();
      cyc++;
    end
    in_valid  = 1'b0;
    mat_ready = 1'b0;
    chk("rnd.drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matrix_stream_loader.md
# matrix_stream_loader

Parametrised successor to the 2x2 byte loader: accepts a ready/valid element stream carrying a 4-beat dimension header followed by two matrices in row-major order, and packs them into flat MAX_DIM x MAX_DIM buffers for the multiplier. Adds dimension/shape checking, sticky error reporting, zero-fill of unused slots, and a valid/ready hand-off to the multiplier. Sits between the chip input deserialiser and the matrix multiplier.

## Interface
- ELEM_W, 8, element and header beat width in bits
- MAX_DIM, 4, maximum rows/cols per matrix (≥2)
- DIM_W, $clog2(MAX_DIM+1), width of dimension fields (derived, do not override)
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- in_data  in  ELEM_W  header value or matrix element
- in_ctrl  in  2  beat kind: 0 DATA, 1 HDR, 2 CLR, 3 reserved
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid & in_ready
- mat_a, mat_b  out  MAX_DIM*MAX_DIM*ELEM_W  packed matrices, slot k = [k*ELEM_W +: ELEM_W]
- r1, c1, r2, c2  out  DIM_W  latched dimensions
- mat_valid  out  1  matrices complete and stable
- mat_ready  in  1  multiplier takes matrices
- err  out  1  sticky error flag
- err_code  out  2  0 none, 1 DIM, 2 SHAPE, 3 SEQ

## Operation
- States: IDLE, HDR, LOAD_A, LOAD_B, HOLD, ERR.
- IDLE: HDR beat stores R1, enters HDR (hdr count=1). DATA beat -> ERR/SEQ. CLR: no-op.
- HDR: beats 2..4 store C1, R2, C2 (low DIM_W bits of in_data; upper bits must be zero, else DIM). On 4th beat check: any dim 0 or > MAX_DIM -> ERR/DIM; else C1≠R2 -> ERR/SHAPE; else zero mat_a, mat_b, reset row/col counters, go LOAD_A. DATA beat in HDR -> ERR/SEQ.
- LOAD_A: each DATA beat writes slot row*MAX_DIM+col of mat_a; col increments, wraps to 0 at c1 with row++. Element R1*C1 (row=r1-1, col=c1-1) -> counters clear, LOAD_B. LOAD_B identical on mat_b with r2/c2; last element -> HOLD. HDR beat in LOAD_* -> ERR/SEQ.
- HOLD: mat_valid=1, in_ready=0. mat_ready high -> IDLE on that edge. Outputs unchanged throughout HOLD.
- ERR: in_ready=1, all beats dropped except CLR; err/err_code held.
- CLR accepted in any state except HOLD: -> IDLE, clears err, err_code, counters; matrices and dims keep values.
- in_ctrl=3 in any accepting state -> ERR/SEQ.
- Counters are row/col, no multiplier in the index path beyond constant MAX_DIM.

## Timing
- Reset: state IDLE; mat_a, mat_b, r1..c2, err, err_code, mat_valid = 0; in_ready = 1.
- in_ready is a registered function of state only (0 only in HOLD); never depends on in_valid.
- Last B element accepted at edge n -> mat_valid=1 from cycle n+1; mat_valid & mat_ready at edge m -> mat_valid=0, in_ready=1 from m+1. mat_ready with mat_valid low ignored.
- Error detected on edge n -> err=1, err_code valid from n+1.
- Stall (in_valid low) holds all state; no timeout.
- RST_N low mid-load: immediate return to reset values; partial data discarded.
- 1x1 matrices: LOAD_A and LOAD_B each last one beat; minimum transfer 6 beats.

## Structure
- Package matrix_loader_pkg: state enum, in_ctrl codes (CTRL_DATA/HDR/CLR), err_code constants, ELEM_W/MAX_DIM defaults.
- Single module; no sub-module. Header checks are combinational in-module; buffer writes are indexed part-selects.

## Test plan
- MAX_DIM=4, header 2,2,2,2, A=1..4, B=5..8 -> mat_valid one cycle after beat 12; mat_a slots 0,1,4,5 = 1,2,3,4; others 0; hold with mat_ready=0 for 5 cycles, then release -> IDLE.
- Header 3,2,2,4, A 6 elems, B 8 elems with random in_valid gaps -> correct slots (A row 2 col 1 at slot 9), mat_valid after 18th accepted beat.
- Header 2,3,2,2 -> err=1, err_code=2 after 4th beat; further DATA ignored; CLR -> err=0, IDLE; valid header then loads normally.
- Header 5,1,1,1 (MAX_DIM=4) -> err_code=1; DATA beat in IDLE -> err_code=3; in_ctrl=3 in LOAD_A -> err_code=3.
- RST_N pulsed low after 3 A elements -> all outputs zero immediately; new full transfer completes correctly.
- 1x1 x 1x1 (values 7, 9) -> mat_a slot0=7, mat_b slot0=9, mat_valid after 6th beat; CLR during HOLD not accepted (in_ready=0).
